sw_speed_sel: RTL and testbench

- Upstream input stage for the LED blinker.
- Synchronises and debounces the ten board slide switches.
- Priority-encodes SW[6:0] into a 7-bit blink step value (tempo) and emits a one-cycle strobe whenever that step changes.
- The blinker adds the step to its 26-bit period counter every cycle, so it consumes a clean, glitch-free, registered tempo instead of raw switch levels.

---
 rtl/sw_speed_pkg.sv | 38 +++
 rtl/sw_speed_sel_debounce.sv | 45 ++++
 rtl/sw_speed_sel.sv | 49 ++++
 tb/tb_sw_speed_sel.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/sw_speed_pkg.sv
// Shared constants for the switch front end and the LED blinker: step width,
// the legal tempo steps, and the priority encoder that maps switches to a step.
package sw_speed_pkg;

  localparam int NUM_SW  = 10;
  localparam int SEL_W   = 7;
  localparam int STEP_W  = 7;

  localparam logic [STEP_W-1:0] STEP_X1   = 7'd1;
  localparam logic [STEP_W-1:0] STEP_X2   = 7'd2;
  localparam logic [STEP_W-1:0] STEP_X5   = 7'd5;
  localparam logic [STEP_W-1:0] STEP_X10  = 7'd10;
  localparam logic [STEP_W-1:0] STEP_X20  = 7'd20;
  localparam logic [STEP_W-1:0] STEP_X50  = 7'd50;
  localparam logic [STEP_W-1:0] STEP_X100 = 7'd100;

  typedef struct packed {
    logic              vld;
    logic [STEP_W-1:0] step;
  } step_sel_t;

  // Lowest set switch wins; vld=0 means no switch is selecting a tempo.
  function automatic step_sel_t enc_step(input logic [SEL_W-1:0] sw);
    step_sel_t r;
    r.vld  = 1'b1;
    r.step = STEP_X1;
    if      (sw[0]) r.step = STEP_X1;
    else if (sw[1]) r.step = STEP_X2;
    else if (sw[2]) r.step = STEP_X5;
    else if (sw[3]) r.step = STEP_X10;
    else if (sw[4]) r.step = STEP_X20;
    else if (sw[5]) r.step = STEP_X50;
    else if (sw[6]) r.step = STEP_X100;
    else            r.vld  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/sw_speed_sel_debounce.sv
// Single-bit 2-flop synchroniser followed by a hold-time debouncer.
// The stable level only moves after the new level holds for DEBOUNCE_CYCLES edges.
module sw_debounce
  import sw_speed_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Any return to the accepted level restarts the count from zero.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sw_stable <= 1'b0;
    end else if (s2 == sw_stable) begin
      cnt       <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt       <= '0;
      sw_stable <= s2;
    end else begin
      cnt       <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sw_speed_sel.sv
// Switch front end for the blinker: debounces all switches, encodes SW[6:0]
// into a registered tempo step and pulses step_chg when the step moves.
module sw_speed_sel
  import sw_speed_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int DEFAULT_STEP    = 1
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] SW,
  output logic [NUM_SW-1:0] sw_stable,
  output logic [STEP_W-1:0] step,
  output logic              step_chg
);

  step_sel_t enc;
  logic      upd;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .sw_raw   (SW[i]),
      .sw_stable(sw_stable[i])
    );
  end

  // SW[9:7] are reported but deliberately never steer the tempo.
  always_comb begin
    enc = enc_step(sw_stable[SEL_W-1:0]);
    upd = enc.vld && (enc.step != step);
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      step     <= STEP_W'(DEFAULT_STEP);
      step_chg <= 1'b0;
    end else begin
      step_chg <= upd;
      if (upd) step <= enc.step;
    end
  end

endmodule

// File: tb/tb_sw_speed_sel.sv
// Directed bench for sw_speed_sel with a short debounce window; step_chg
// pulses are checked by a monitor against a queue of expected (step, edge) pairs.
module tb_sw_speed_sel;

  localparam int DB = 8;

  logic       CLOCK_50 = 1'b0;
  logic       rst_n    = 1'b1;
  logic [9:0] SW       = '0;
  logic [9:0] sw_stable;
  logic [6:0] step;
  logic       step_chg;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [6:0] step;
    int         edge_no;
  } exp_t;
  exp_t exp_q[$];

  sw_speed_sel #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4),
    .DEFAULT_STEP   (1)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .SW       (SW),
    .sw_stable(sw_stable),
    .step     (step),
    .step_chg (step_chg)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Inputs change and direct checks happen 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic expect_pulse(input logic [6:0] s, input int t0);
    exp_t e;
    e.step    = s;
    e.edge_no = t0 + 2 + DB + 1;
    exp_q.push_back(e);
  endtask

  always @(negedge CLOCK_50) begin
    if (step_chg === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_step_chg", 32'(step), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_step", 32'(step), 32'(e.step));
        chk("pulse_edge", 32'(cyc), 32'(e.edge_no));
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].edge_no) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("missing_step_chg", 32'(cyc), 32'(e.edge_no));
    end
  end

  initial begin
    int t0;
    // Reset with all switches already up
    SW = 10'h3FF;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_step", 32'(step), 1);
    chk("rst_stable", 32'(sw_stable), 0);
    chk("rst_chg", 32'(step_chg), 0);
    rst_n = 1'b1;
    for (int i = 1; i < 2 + DB; i++) begin
      tick(1);
      if (sw_stable !== 10'h0 || step !== 7'd1 || step_chg !== 1'b0)
        chk("rel_hold", {5'd0, sw_stable, 2'd0, step, step_chg}, {5'd0, 10'h0, 2'd0, 7'd1, 1'b0});
    end
    n_chk++;
    tick(1);
    chk("rel_stable_edge10", 32'(sw_stable), 32'h3FF);
    tick(1);
    chk("rel_step_same", 32'(step), 1);

    // Return to all-zero: no selection, step holds
    SW = 10'h000;
    tick(14);
    chk("zero_stable", 32'(sw_stable), 0);
    chk("zero_hold", 32'(step), 1);

    // Clean select SW3
    SW = 10'h008; t0 = cyc;
    expect_pulse(7'd10, t0);
    tick(2 + DB - 1);
    chk("sel3_pre", 32'(sw_stable[3]), 0);
    tick(1);
    chk("sel3_stable", 32'(sw_stable[3]), 1);
    chk("sel3_step_pre", 32'(step), 1);
    tick(1);
    chk("sel3_step", 32'(step), 10);
    SW = 10'h000;
    tick(14);
    chk("sel3_hold", 32'(step), 10);

    // Bouncing SW5
    SW[5] = 1'b1; tick(5);
    SW[5] = 1'b0; tick(2);
    SW[5] = 1'b1; t0 = cyc;
    expect_pulse(7'd50, t0);
    tick(2 + DB - 1);
    chk("bnc_stable_pre", 32'(sw_stable[5]), 0);
    tick(1);
    chk("bnc_step_pre", 32'(step), 10);
    tick(3);
    chk("bnc_step", 32'(step), 50);

    // Priority: SW2 beats SW6
    SW = 10'h044; t0 = cyc;
    expect_pulse(7'd5, t0);
    tick(14);
    chk("pri_step5", 32'(step), 5);
    SW = 10'h040; t0 = cyc;
    expect_pulse(7'd100, t0);
    tick(14);
    chk("pri_step100", 32'(step), 100);
    SW = 10'h000;
    tick(14);
    chk("nosel_hold", 32'(step), 100);
    SW = 10'h380;
    tick(14);
    chk("hi_stable", 32'(sw_stable), 32'h380);
    chk("hi_hold", 32'(step), 100);

    // Reset in the middle of debouncing SW1
    SW = 10'h002;
    tick(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_step", 32'(step), 1);
    chk("mid_rst_stable", 32'(sw_stable), 0);
    tick(3);
    chk("mid_rst_step2", 32'(step), 1);
    rst_n = 1'b1; t0 = cyc;
    expect_pulse(7'd2, t0);
    tick(2 + DB);
    chk("mid_step_pre", 32'(step), 1);
    tick(1);
    chk("mid_step", 32'(step), 2);

    tick(10);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
